// File: rtl/mips_bus_arbiter_if.sv
// Bus bundle between the two CPU-side masters, the arbiter and the memory.
// All master-side (m0_*, m1_*, m_readdata) and memory-side (s_*) signals
// live here so the arbiter takes a single port.
//   slave  modport : the arbiter's view (accepts master requests, drives memory)
//   master modport : the environment's view (masters plus memory)
interface mips_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // master 0 (mips_cpu_bus core)
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_waitrequest;

    // master 1 (test loader / DMA)
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_waitrequest;

    // shared read data back to both masters
    logic [DATA_W-1:0] m_readdata;

    // memory port
    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;

    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        output m0_waitrequest,
        input  m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        output m1_waitrequest,
        output m_readdata,
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_waitrequest, s_readdata
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata, m0_byteenable,
        input  m0_waitrequest,
        output m1_address, m1_read, m1_write, m1_writedata, m1_byteenable,
        input  m1_waitrequest,
        input  m_readdata,
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_waitrequest, s_readdata
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave round-robin arbiter for the CPU memory bus.
// One transfer at a time: IDLE arbitrates, ISSUE presents the owner's strobes
// to memory until accepted, RDATA returns the one-cycle-latency read word.
// Ports:
//   clk    - clock, all state on rising edge
//   reset  - asynchronous active-low reset
//   bus    - mips_bus_arbiter_if.slave (m0_*, m1_*, m_readdata, s_*)
//   grant  - current/last owner (0 = m0, 1 = m1)
//   busy   - high whenever a transfer is in progress (state != IDLE)
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_bus_arbiter_if.slave     bus,
    output logic                  grant,
    output logic                  busy
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              grant_nxt;
    logic              last, last_nxt;     // last master that completed a transfer
    logic              req0, req1;
    logic              own_read, own_write;
    logic              owner_ack;          // owner's transfer completes this cycle
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [BE_W-1:0]   be_mux;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    assign own_read  = grant ? bus.m1_read  : bus.m0_read;
    assign own_write = grant ? bus.m1_write : bus.m0_write;

    // Address/data path always follows the granted master, whatever the state.
    assign addr_mux  = grant ? bus.m1_address    : bus.m0_address;
    assign wdata_mux = grant ? bus.m1_writedata  : bus.m0_writedata;
    assign be_mux    = grant ? bus.m1_byteenable : bus.m0_byteenable;

    assign bus.s_address    = addr_mux;
    assign bus.s_writedata  = wdata_mux;
    assign bus.s_byteenable = be_mux;

    // Memory registers its read data, so it is already aligned with RDATA.
    assign bus.m_readdata = bus.s_readdata;

    // State register. Reset leaves the pointer at m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    grant_nxt = ~last;
                    state_nxt = ISSUE;
                end else if (req0) begin
                    grant_nxt = 1'b0;
                    state_nxt = ISSUE;
                end else if (req1) begin
                    grant_nxt = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!own_read && !own_write) begin
                    // Owner abandoned the request: no transfer, pointer kept.
                    state_nxt = IDLE;
                end else if (!bus.s_waitrequest) begin
                    if (own_write) begin
                        state_nxt = IDLE;
                        last_nxt  = grant;
                    end else begin
                        state_nxt = RDATA;
                    end
                end
            end
            RDATA: begin
                state_nxt = IDLE;
                last_nxt  = grant;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. A simultaneous read+write is forwarded as a write only.
    always_comb begin
        bus.s_read  = 1'b0;
        bus.s_write = 1'b0;
        owner_ack   = 1'b0;
        busy        = (state != IDLE);
        case (state)
            ISSUE: begin
                bus.s_write = own_write;
                bus.s_read  = own_read & ~own_write;
                owner_ack   = own_write & ~bus.s_waitrequest;
            end
            RDATA: owner_ack = 1'b1;
            default: ;
        endcase
    end

    // The non-granted master is always stalled.
    assign bus.m0_waitrequest = ~(owner_ack & ~grant);
    assign bus.m1_waitrequest = ~(owner_ack &  grant);

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Two-master, one-slave arbiter for the CPU memory bus (address/read/write/waitrequest/writedata/byteenable/readdata). Master 0 is the mips_cpu_bus core; master 1 is a secondary requester (test loader / DMA). The block grants the single memory port one transfer at a time with round-robin fairness and forwards waitrequest and readdata back to the owner. Slave read latency is fixed at one cycle: readdata is registered on the edge that accepts the read.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byteenable width = DATA_W/8)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
m0_address  input  ADDR_W  master 0 byte address
m0_read  input  1  master 0 read request
m0_write  input  1  master 0 write request
m0_writedata  input  DATA_W  master 0 write data
m0_byteenable  input  DATA_W/8  master 0 byte enables
m0_waitrequest  output  1  master 0 stall; 0 = transfer completes this cycle
m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_waitrequest  as m0 for master 1
m_readdata  output  DATA_W  shared read data, valid only when requester's waitrequest = 0 on a read
s_address  output  ADDR_W  to memory
s_read  output  1  to memory
s_write  output  1  to memory
s_writedata  output  DATA_W  to memory
s_byteenable  output  DATA_W/8  to memory
s_waitrequest  input  1  memory stall
s_readdata  input  DATA_W  memory read data, registered by memory
grant  output  1  current/last owner (0 = m0, 1 = m1)
busy  output  1  1 when state != IDLE

Behaviour:
- Reset (reset = 0, async): state IDLE, grant = 0, last-served pointer = 1 (so m0 wins first tie), s_read = s_write = 0, m0/m1_waitrequest = 1, busy = 0. Any in-flight transfer is abandoned; s_read/s_write drop immediately.
- A request is read | write. read & write together is illegal; the arbiter forwards write only (s_read = read & ~write).
- Masters hold all request signals stable while their waitrequest = 1.
- Non-granted master's waitrequest is always 1.
- s_address/s_writedata/s_byteenable are muxed from the granted master in all states. m_readdata = s_readdata at all times.
- States:
  - IDLE: s_read = s_write = 0.
    - One requester: grant it.
    - Both requesting: grant the master not in the last-served pointer.
    - On grant, go to ISSUE. No requester: stay.
  - ISSUE: s_read/s_write follow the granted master's strobes.
    - s_waitrequest = 1: hold ISSUE, owner waitrequest = 1.
    - Write with s_waitrequest = 0: owner waitrequest = 0 this cycle (combinational). Go to IDLE and set last-served = grant.
    - Read with s_waitrequest = 0: owner waitrequest = 1. Go to RDATA.
    - Owner drops both strobes (protocol violation): go to IDLE, no transfer, pointer unchanged.
  - RDATA: s_read = s_write = 0, owner waitrequest = 0. The owner samples m_readdata on this edge. Go to IDLE and set last-served = grant.
- Latency with zero memory stalls, counted from the edge where IDLE samples the request:
  - write completes at the edge ending ISSUE (2 cycles);
  - read completes at the edge ending RDATA (3 cycles).
  - Each s_waitrequest cycle adds 1.
- Back-to-back: after completion, IDLE arbitrates afresh, so a master with continuous requests alternates with the other and cannot starve it.
- grant holds its value in IDLE until the next grant.

Test Plan:
- Reset asserted mid-ISSUE with m0 reading 0xBFC00004 -> s_read = 0 and m0_waitrequest = 1 immediately; after release, grant = 0 and busy = 0.
- m0 read at 0xBFC00000, memory word 0x3C08BFC0, no stalls -> s_read high exactly 1 cycle; m0_waitrequest low in 3rd cycle; m_readdata = 0x3C08BFC0.
- m1 write 0xDEADBEEF, byteenable 4'b1111, to 0xBFC0002C with s_waitrequest high 3 cycles -> s_write held 4 cycles; m1_waitrequest low only in the accepting cycle; the memory word then reads 0xDEADBEEF.
- m0 and m1 request reads simultaneously from reset -> m0 served first, then m1. With both continuously requesting, grant sequence is 0,1,0,1 and m1_waitrequest never drops while grant = 0.
- m0 asserts read and write together, byteenable 4'b0001 -> only s_write asserted, s_read = 0; the write completes in 2 cycles.
- m0 drops strobes during ISSUE while s_waitrequest = 1 -> return to IDLE; pointer unchanged, so the next tie still favours the same master.
